// File: rtl/kws_pkg.sv
// Shared definitions for the keyword-spotting parameter loaders.
// Holds the frame header layout, layer ids, payload kinds and the loader
// state encoding. There are no ports; this file only declares constants and types.
package kws_pkg;

    localparam logic [3:0] HDR_SYNC = 4'hA;

    localparam logic [3:0] LID_CONV1 = 4'd0;
    localparam logic [3:0] LID_CONV2 = 4'd1;
    localparam logic [3:0] LID_FC1   = 4'd2;
    localparam logic [3:0] LID_FC2   = 4'd3;

    // Header word layout
    localparam int HDR_SYNC_MSB = 15;
    localparam int HDR_SYNC_LSB = 12;
    localparam int HDR_ID_MSB   = 11;
    localparam int HDR_ID_LSB   = 8;
    localparam int HDR_KIND_BIT = 7;

    localparam logic KIND_WEIGHTS = 1'b0;
    localparam logic KIND_BIASES  = 1'b1;

    typedef enum logic [1:0] {
        ST_HDR    = 2'd0,
        ST_DATA   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_COMMIT = 2'd3
    } loader_state_t;

endpackage

// File: rtl/kws_param_loader.sv
// Word-serial weight/bias loader for one layer.
// It takes framed 16-bit words from a valid/ready stream and assembles them into
// a staging vector. On a complete, well-formed frame it commits the vector to
// weights_out or biases_out and pulses the matching load strobe for one cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_data/s_valid/s_last stream input (header word first, then payload)
//   s_ready               loader accepts a word this cycle
//   weights_out           committed weight vector (word 0 in the LSBs)
//   biases_out            committed bias vector (word 0 in the LSBs)
//   load_weights          one-cycle strobe, weights_out just updated
//   load_biases           one-cycle strobe, biases_out just updated
//   frame_error           one-cycle pulse for a malformed frame
//   busy                  state is not HDR
//
// state  | meaning
// HDR    | waiting for a header word
// DATA   | collecting payload words into staging
// DRAIN  | discarding words up to s_last (foreign or bad frame)
// COMMIT | staging copied out, load strobe high, s_ready low
module kws_param_loader
    import kws_pkg::*;
#(
    parameter int ACTIV_BITS   = 16,
    parameter int WEIGHT_WORDS = 72,
    parameter int BIAS_WORDS   = 8,
    parameter int TARGET_ID    = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [ACTIV_BITS-1:0]              s_data,
    input  logic                               s_valid,
    input  logic                               s_last,
    output logic                               s_ready,
    output logic [WEIGHT_WORDS*ACTIV_BITS-1:0] weights_out,
    output logic [BIAS_WORDS*ACTIV_BITS-1:0]   biases_out,
    output logic                               load_weights,
    output logic                               load_biases,
    output logic                               frame_error,
    output logic                               busy
);

    localparam int STAGE_WORDS = (WEIGHT_WORDS > BIAS_WORDS) ? WEIGHT_WORDS : BIAS_WORDS;
    localparam int CW          = $clog2(STAGE_WORDS + 1);

    loader_state_t                       state;
    logic                                kind;
    logic [CW-1:0]                       cnt;
    logic [STAGE_WORDS*ACTIV_BITS-1:0]   stage;

    logic                                xfer;
    logic [CW-1:0]                       cnt_inc;
    logic [CW-1:0]                       n_words;
    logic [STAGE_WORDS*ACTIV_BITS-1:0]   stage_next;
    logic                                hdr_sync_ok;
    logic                                hdr_id_ok;

    assign xfer        = s_valid && s_ready;
    assign cnt_inc     = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
    assign n_words     = (kind == KIND_BIASES) ? CW'(BIAS_WORDS) : CW'(WEIGHT_WORDS);
    assign hdr_sync_ok = (s_data[HDR_SYNC_MSB:HDR_SYNC_LSB] == HDR_SYNC);
    assign hdr_id_ok   = (s_data[HDR_ID_MSB:HDR_ID_LSB] == 4'(TARGET_ID));
    assign busy        = (state != ST_HDR);

    // Staging including the word on the bus, so the last word of a frame can
    // be committed on the same edge it is accepted.
    always_comb begin
        stage_next = stage;
        stage_next[int'(cnt)*ACTIV_BITS +: ACTIV_BITS] = s_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_HDR;
            kind         <= KIND_WEIGHTS;
            cnt          <= '0;
            stage        <= '0;
            s_ready      <= 1'b0;
            weights_out  <= '0;
            biases_out   <= '0;
            load_weights <= 1'b0;
            load_biases  <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            s_ready      <= 1'b1;
            load_weights <= 1'b0;
            load_biases  <= 1'b0;
            frame_error  <= 1'b0;
            case (state)
                ST_HDR: begin
                    if (xfer) begin
                        if (!hdr_sync_ok) begin
                            frame_error <= 1'b1;
                            state       <= s_last ? ST_HDR : ST_DRAIN;
                        end else if (!hdr_id_ok) begin
                            state <= s_last ? ST_HDR : ST_DRAIN;
                        end else if (s_last) begin
                            // header with no payload
                            frame_error <= 1'b1;
                        end else begin
                            kind  <= s_data[HDR_KIND_BIT];
                            cnt   <= '0;
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        stage <= stage_next;
                        if (cnt_inc == n_words) begin
                            if (s_last) begin
                                if (kind == KIND_BIASES) begin
                                    biases_out  <= stage_next[BIAS_WORDS*ACTIV_BITS-1:0];
                                    load_biases <= 1'b1;
                                end else begin
                                    weights_out  <= stage_next[WEIGHT_WORDS*ACTIV_BITS-1:0];
                                    load_weights <= 1'b1;
                                end
                                s_ready <= 1'b0;
                                state   <= ST_COMMIT;
                            end else begin
                                frame_error <= 1'b1;
                                state       <= ST_DRAIN;
                            end
                        end else if (s_last) begin
                            frame_error <= 1'b1;
                            state       <= ST_HDR;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (xfer && s_last) begin
                        state <= ST_HDR;
                    end
                end
                ST_COMMIT: begin
                    state <= ST_HDR;
                end
                default: begin
                    state <= ST_HDR;
                end
            endcase
        end
    end

endmodule

// File: doc/kws_param_loader.md
Name: kws_param_loader

Overview:
Word-serial parameter loader, one instance per layer (conv1, conv2, fc1, fc2). It is the writer side of the layer weight/bias load interface.
- Accepts 16-bit framed words on a valid/ready stream from the host/DMA side.
- Assembles each frame into a wide weight or bias vector.
- Presents the vector on a stable bus and pulses the matching load strobe for one cycle.
- The layer samples the bus on that strobe; a layer never sees a partial update.

Parameters:
ACTIV_BITS, 16, width of one parameter word and of the stream data.
WEIGHT_WORDS, 72, number of words in the weight vector (conv1 default 8*3*3).
BIAS_WORDS, 8, number of words in the bias vector.
TARGET_ID, 0, 4-bit layer id this instance answers to (0 conv1, 1 conv2, 2 fc1, 3 fc2).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_data  in  ACTIV_BITS  stream word (header or payload)
s_valid  in  1  s_data valid
s_last  in  1  marks final word of frame
s_ready  out  1  loader accepts word this cycle
weights_out  out  WEIGHT_WORDS*ACTIV_BITS  committed weight vector
biases_out  out  BIAS_WORDS*ACTIV_BITS  committed bias vector
load_weights  out  1  one-cycle commit strobe for weights_out
load_biases  out  1  one-cycle commit strobe for biases_out
frame_error  out  1  one-cycle pulse on a malformed frame
busy  out  1  high whenever state is not HDR

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0 and s_ready 0 while rst_n is low.
  - State HDR; staging register and word counter cleared.
  - s_ready is 1 from the first cycle after release.
- Transfer occurs when s_valid && s_ready on a rising edge.
- Frame format:
  - One header word, then payload.
  - Header: [15:12] sync = 4'hA, [11:8] target id, [7] kind (0 weights, 1 biases), [6:0] ignored.
  - Payload word i goes to bits [i*ACTIV_BITS +: ACTIV_BITS] (word 0 = LSBs).
- States:
  - HDR: s_ready=1. On a header transfer:
    - bad sync -> DRAIN, pulse frame_error.
    - id != TARGET_ID -> DRAIN, no error.
    - otherwise latch kind, set expected count N (WEIGHT_WORDS or BIAS_WORDS), clear counter -> DATA.
    - A header transfer with s_last=1 and a valid id/sync is an error (empty frame) -> HDR, pulse frame_error.
  - DATA: s_ready=1; each transfer writes the staging slot and increments the counter.
    - Counter reaches N with s_last=1 -> commit on the same edge -> COMMIT:
      - copy staging (including the current word) into weights_out or biases_out;
      - set the matching load_* strobe to 1.
    - s_last=1 before N words -> frame_error, no commit -> HDR.
    - N-th word without s_last -> frame_error, no commit -> DRAIN.
  - DRAIN: s_ready=1; discard words until a transfer with s_last=1 -> HDR. A word transfer that would carry s_last=1 while already in HDR is a header, not a drain end.
  - COMMIT: one cycle; s_ready=0; the load_* strobe is high in this cycle only -> HDR.
- Timing:
  - Strobe and new bus value are visible the cycle after the last word is accepted.
  - Earliest next header is accepted 2 cycles after the last payload word.
- weights_out and biases_out change only at commit and hold their value otherwise. Error frames leave them untouched. The staging register is never visible on the outputs.
- load_weights and load_biases are never high together. Neither is high together with frame_error.
- Counter width is $clog2(max(WEIGHT_WORDS,BIAS_WORDS)+1). The counter saturates and does not wrap.
- Reset mid-frame: the partial frame is discarded, outputs return to 0, and there is no strobe.
- s_valid may toggle freely mid-frame; bubbles have no effect.

Decomposition:
- Shared package kws_pkg holds:
  - HDR_SYNC = 4'hA;
  - layer id constants LID_CONV1..LID_FC2 (0..3);
  - header field bit positions;
  - KIND_WEIGHTS/KIND_BIASES.
- No sub-module needed. FSM, counter and staging live in one module. The top level instantiates four loaders fanned from one stream, with s_ready ANDed across the instances.

Test Plan:
- Conv1 weights: header 16'hA000, then 72 words 16'h0100+i, last on word 71 -> load_weights=1 for exactly 1 cycle; weights_out[15:0]=16'h0100; weights_out[1151:1136]=16'h0147; biases_out stays 0.
- Biases: header 16'hA080, then 8 words 16'hFFF0+i -> load_biases pulse; biases_out[127:112]=16'hFFF7; weights_out unchanged.
- Foreign target: header 16'hA300 plus 72 words -> no strobe, no error; busy high until s_last, then HDR.
- Short frame: header 16'hA080 with s_last on the 5th payload word -> frame_error 1 cycle, no strobe; biases_out keeps its prior value. A following good frame commits normally.
- Bad sync 16'h5000 -> frame_error; words drained to s_last. Randomised s_valid gaps on a good frame -> identical result to the gap-free run.
- rst_n low after 30 payload words -> outputs 0, s_ready 0 during reset. After release, a full good frame loads correctly.
